// File: rtl/master_req_pkg.sv
// Shared types for the per-master request buffer.
// Used by master_req_fifo and its testbench.
package master_req_pkg;

    localparam int MRF_ADDR_WIDTH = 32;
    localparam int MRF_DATA_WIDTH = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef struct packed {
        logic [MRF_ADDR_WIDTH-1:0] addr;
        logic                      cmd;
        logic [MRF_DATA_WIDTH-1:0] wdata;
    } req_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } fsm_state_t;

endpackage

// File: rtl/master_req_fifo_sync_fifo.sv
// Request storage: circular buffer with head and head+1 peek ports.
// DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic [WIDTH-1:0]         o_next,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    w_rd_nxt;
    logic             w_push;
    logic             w_pop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign w_push   = i_push & ~o_full;
    assign w_pop    = i_pop & ~o_empty;
    assign w_rd_nxt = r_rd_ptr + AW'(1);
    assign o_head   = r_mem[r_rd_ptr];
    assign o_next   = r_mem[w_rd_nxt];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/master_req_fifo.sv
// Per-master request buffer replaying queued requests to the cross_bar.
// Optional MASTER_REQ_FIFO_STATS_EN adds saturating accept/stall counters.
module master_req_fifo
    import master_req_pkg::*;
#(
    parameter int ADDR_WIDTH = MRF_ADDR_WIDTH,
    parameter int DATA_WIDTH = MRF_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_req,
    input  logic [ADDR_WIDTH-1:0]   m_addr,
    input  logic                    m_cmd,
    input  logic [DATA_WIDTH-1:0]   m_wdata,
    output logic                    m_ack,
    output logic                    m_resp,
    output logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    xb_req,
    output logic [ADDR_WIDTH-1:0]   xb_addr,
    output logic                    xb_cmd,
    output logic [DATA_WIDTH-1:0]   xb_wdata,
    input  logic                    xb_ack,
    input  logic                    xb_resp,
    input  logic [DATA_WIDTH-1:0]   xb_rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef MASTER_REQ_FIFO_STATS_EN
    ,
    output logic [15:0]             stat_accepted,
    output logic [15:0]             stat_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + 1 + DATA_WIDTH;

    fsm_state_t            r_state;
    fsm_state_t            w_state_nxt;
    logic [EW-1:0]         w_in;
    logic [EW-1:0]         w_head;
    logic [EW-1:0]         w_next;
    logic [EW-1:0]         w_sel;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_resp;
    logic                  w_deep;
    logic                  w_more;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [ADDR_WIDTH-1:0] r_xb_addr;
    logic                  r_xb_cmd;
    logic [DATA_WIDTH-1:0] r_xb_wdata;
    logic                  r_m_resp;
    logic [DATA_WIDTH-1:0] r_m_rdata;

    assign w_in   = {m_addr, m_cmd, m_wdata};
    // Acceptance looks only at full: a pop in the same cycle never frees a slot early.
    assign w_push = m_req & ~w_full;
    assign w_deep = (w_count > CW'(1));
    assign w_more = w_deep | w_push;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_in),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_resp      = 1'b0;
        w_sel       = w_in;
        unique case (r_state)
            IDLE: begin
                if (!w_empty || w_push) begin
                    w_state_nxt = ISSUE;
                    w_load      = 1'b1;
                    w_sel       = w_empty ? w_in : w_head;
                end
            end
            ISSUE: begin
                if (xb_ack) begin
                    if (r_xb_cmd == CMD_WRITE) begin
                        w_pop       = 1'b1;
                        w_load      = w_more;
                        w_sel       = w_deep ? w_next : w_in;
                        w_state_nxt = w_more ? ISSUE : IDLE;
                    end else begin
                        w_state_nxt = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (xb_resp) begin
                    w_pop       = 1'b1;
                    w_resp      = 1'b1;
                    w_load      = w_more;
                    w_sel       = w_deep ? w_next : w_in;
                    w_state_nxt = w_more ? ISSUE : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_xb_addr  <= '0;
            r_xb_cmd   <= 1'b0;
            r_xb_wdata <= '0;
            r_m_resp   <= 1'b0;
            r_m_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_m_resp <= w_resp;
            if (w_resp) begin
                r_m_rdata <= xb_rdata;
            end
            if (w_load) begin
                {r_xb_addr, r_xb_cmd, r_xb_wdata} <= w_sel;
            end
        end
    end

    assign m_ack    = w_push;
    assign m_resp   = r_m_resp;
    assign m_rdata  = r_m_rdata;
    assign xb_req   = (r_state == ISSUE);
    assign xb_addr  = r_xb_addr;
    assign xb_cmd   = r_xb_cmd;
    assign xb_wdata = r_xb_wdata;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = w_count;

`ifdef MASTER_REQ_FIFO_STATS_EN
    logic [15:0] r_stat_acc;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_acc   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_push && (r_stat_acc != 16'hFFFF)) begin
                r_stat_acc <= r_stat_acc + 16'd1;
            end
            if (m_req && w_full && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_accepted = r_stat_acc;
    assign stat_stall    = r_stat_stall;
`endif

endmodule

// File: tb/tb_master_req_fifo.sv
// Directed bench for master_req_fifo with a scoreboard monitor on
// cross_bar issue handshakes and master read responses.
module tb_master_req_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_cmd;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic        m_resp;
    logic [31:0] m_rdata;
    logic        xb_req;
    logic [31:0] xb_addr;
    logic        xb_cmd;
    logic [31:0] xb_wdata;
    logic        xb_ack;
    logic        xb_resp;
    logic [31:0] xb_rdata;
    logic        full;
    logic        empty;
    logic [2:0]  count;
`ifdef MASTER_REQ_FIFO_STATS_EN
    logic [15:0] stat_accepted;
    logic [15:0] stat_stall;
`endif

    always #5 clk = ~clk;

    master_req_fifo #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_cmd    (m_cmd),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_resp   (m_resp),
        .m_rdata  (m_rdata),
        .xb_req   (xb_req),
        .xb_addr  (xb_addr),
        .xb_cmd   (xb_cmd),
        .xb_wdata (xb_wdata),
        .xb_ack   (xb_ack),
        .xb_resp  (xb_resp),
        .xb_rdata (xb_rdata),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef MASTER_REQ_FIFO_STATS_EN
        ,
        .stat_accepted (stat_accepted),
        .stat_stall    (stat_stall)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        cmd;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_issue[$];
    logic [31:0] exp_rdata[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [31:0] a,
                         input logic c, input logic [31:0] d);
        m_req   = req;
        m_addr  = a;
        m_cmd   = c;
        m_wdata = d;
    endtask

    task automatic expect_issue(input logic [31:0] a, input logic c,
                                input logic [31:0] d);
        txn_t t;
        t.addr  = a;
        t.cmd   = c;
        t.wdata = d;
        exp_issue.push_back(t);
    endtask

    // Monitor: every accepted cross_bar request and every master response
    // is checked against the scoreboard queues in order.
    initial begin
        txn_t        e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (rst_n && xb_req && xb_ack) begin
                if (exp_issue.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL issue_unexpected: got addr %0h expected none",
                             xb_addr);
                end else begin
                    e = exp_issue.pop_front();
                    chk("issue_addr", 64'(xb_addr), 64'(e.addr));
                    chk("issue_cmd", 64'(xb_cmd), 64'(e.cmd));
                    chk("issue_wdata", 64'(xb_wdata), 64'(e.wdata));
                end
            end
            if (m_resp) begin
                if (exp_rdata.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got rdata %0h expected no m_resp",
                             m_rdata);
                end else begin
                    r = exp_rdata.pop_front();
                    chk("resp_rdata", 64'(m_rdata), 64'(r));
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        xb_ack   = 1'b0;
        xb_resp  = 1'b0;
        xb_rdata = 32'h0;
        #2;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_xb_req", 64'(xb_req), 64'd0);
        chk("rst_m_resp", 64'(m_resp), 64'd0);
        chk("rst_m_rdata", 64'(m_rdata), 64'd0);
        chk("rst_xb_fields", {31'd0, xb_cmd, xb_addr}, 64'd0);
        chk("rst_xb_wdata", 64'(xb_wdata), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Single write, acked after a short stall
        drive(1'b1, 32'h4000_0010, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("w1_m_ack", 64'(m_ack), 64'd1);
        expect_issue(32'h4000_0010, 1'b1, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("w1_xb_req", 64'(xb_req), 64'd1);
        chk("w1_xb_addr", 64'(xb_addr), 64'h4000_0010);
        chk("w1_xb_wdata", 64'(xb_wdata), 64'hDEAD_BEEF);
        chk("w1_count", 64'(count), 64'd1);
        step();
        chk("w1_hold_req", 64'(xb_req), 64'd1);
        step();
        chk("w1_hold_addr", 64'(xb_addr), 64'h4000_0010);
        xb_ack = 1'b1;
        step();
        xb_ack = 1'b0;
        #1;
        chk("w1_done_count", 64'(count), 64'd0);
        chk("w1_done_req", 64'(xb_req), 64'd0);
        chk("w1_done_empty", 64'(empty), 64'd1);

        // Single read with delayed response
        drive(1'b1, 32'hC000_0004, 1'b0, 32'h0);
        #1;
        chk("r1_m_ack", 64'(m_ack), 64'd1);
        expect_issue(32'hC000_0004, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        xb_ack = 1'b1;
        #1;
        chk("r1_xb_req", 64'(xb_req), 64'd1);
        chk("r1_xb_cmd", 64'(xb_cmd), 64'd0);
        step();
        xb_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("r1_wait_req_low", 64'(xb_req), 64'd0);
            chk("r1_wait_no_resp", 64'(m_resp), 64'd0);
            if (i < 2) step();
        end
        xb_resp  = 1'b1;
        xb_rdata = 32'h1234_5678;
        exp_rdata.push_back(32'h1234_5678);
        step();
        xb_resp  = 1'b0;
        xb_rdata = 32'h0;
        #1;
        chk("r1_m_resp", 64'(m_resp), 64'd1);
        chk("r1_m_rdata", 64'(m_rdata), 64'h1234_5678);
        chk("r1_count", 64'(count), 64'd0);
        chk("r1_req_after", 64'(xb_req), 64'd0);
        step();
        chk("r1_resp_pulse_end", 64'(m_resp), 64'd0);

        // Fill to DEPTH with xb_ack low; 5th request refused until a pop
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0000_1000 + 32'(i * 4), 1'b1, 32'hA0 + 32'(i));
            #1;
            chk("fill_m_ack", 64'(m_ack), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) begin
                expect_issue(32'h0000_1000 + 32'(i * 4), 1'b1, 32'hA0 + 32'(i));
                step();
            end
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd4);
        xb_ack = 1'b1;
        #1;
        chk("fill_no_bypass", 64'(m_ack), 64'd0);
        step();
        xb_ack = 1'b0;
        #1;
        chk("fill_after_pop_count", 64'(count), 64'd3);
        chk("fill_5th_ack", 64'(m_ack), 64'd1);
        expect_issue(32'h0000_1010, 1'b1, 32'hA4);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("fill_refull", 64'(count), 64'd4);
        xb_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_count", 64'(count), 64'(3 - k));
        end
        xb_ack = 1'b0;

        // Write / read / write queued, then serviced immediately
        drive(1'b1, 32'h0000_2000, 1'b1, 32'h11);
        expect_issue(32'h0000_2000, 1'b1, 32'h11);
        step();
        drive(1'b1, 32'h0000_2004, 1'b0, 32'h0);
        expect_issue(32'h0000_2004, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h0000_2008, 1'b1, 32'h33);
        expect_issue(32'h0000_2008, 1'b1, 32'h33);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("mix_count3", 64'(count), 64'd3);
        xb_ack = 1'b1;
        step();
        chk("mix_count2", 64'(count), 64'd2);
        chk("mix_head_read", 64'(xb_cmd), 64'd0);
        step();
        chk("mix_wait_count", 64'(count), 64'd2);
        chk("mix_wait_req", 64'(xb_req), 64'd0);
        xb_ack   = 1'b0;
        xb_resp  = 1'b1;
        xb_rdata = 32'hCAFE_F00D;
        exp_rdata.push_back(32'hCAFE_F00D);
        step();
        xb_resp  = 1'b0;
        xb_rdata = 32'h0;
        #1;
        chk("mix_count1", 64'(count), 64'd1);
        chk("mix_m_resp", 64'(m_resp), 64'd1);
        chk("mix_reissue", 64'(xb_req), 64'd1);
        xb_ack = 1'b1;
        step();
        xb_ack = 1'b0;
        #1;
        chk("mix_count0", 64'(count), 64'd0);
        chk("mix_no_resp", 64'(m_resp), 64'd0);

        // Wrap-around: 10 writes, pointers cycle through DEPTH twice
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h0000_3000 + 32'(i * 4), 1'b1, 32'h100 + 32'(i));
            xb_ack = (i >= 3);
            #1;
            chk("wrap_m_ack", 64'(m_ack), 64'd1);
            expect_issue(32'h0000_3000 + 32'(i * 4), 1'b1, 32'h100 + 32'(i));
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap_steady_count", 64'(count), 64'd3);
        xb_ack = 1'b1;
        repeat (3) step();
        xb_ack = 1'b0;
        #1;
        chk("wrap_count0", 64'(count), 64'd0);
        chk("wrap_empty", 64'(empty), 64'd1);
        chk("sb_issue_drained", 64'(exp_issue.size()), 64'd0);
        chk("sb_resp_drained", 64'(exp_rdata.size()), 64'd0);

        // Reset while waiting on a read with three entries queued
        drive(1'b1, 32'h8000_0000, 1'b0, 32'h0);
        expect_issue(32'h8000_0000, 1'b0, 32'h0);
        step();
        drive(1'b1, 32'h8000_0004, 1'b1, 32'h1);
        step();
        drive(1'b1, 32'h8000_0008, 1'b1, 32'h2);
        xb_ack = 1'b1;
        #1;
        chk("mid_m_ack3", 64'(m_ack), 64'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        xb_ack = 1'b0;
        #1;
        chk("mid_count3", 64'(count), 64'd3);
        chk("mid_wait_req", 64'(xb_req), 64'd0);
        chk("mid_read_issued", 64'(exp_issue.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(xb_req), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_empty", 64'(empty), 64'd1);
        exp_issue.delete();
        step();
        rst_n    = 1'b1;
        xb_resp  = 1'b1;
        xb_rdata = 32'hBAD0_BAD0;
        step();
        xb_resp  = 1'b0;
        xb_rdata = 32'h0;
        #1;
        chk("late_resp_ignored", 64'(m_resp), 64'd0);
        step();
        chk("late_resp_ignored2", 64'(m_resp), 64'd0);
        chk("late_count", 64'(count), 64'd0);
        chk("late_req", 64'(xb_req), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/master_req_fifo.md
Name: master_req_fifo

Overview:
- Per-master request buffer placed between one bus master and its cross_bar master port.
- Accepts a request in the same cycle whenever there is buffer space, queues up to DEPTH requests, and replays them to the cross_bar one at a time: hold req until ack, and for reads wait for resp.
- Decouples master issue from arbitration stalls.
- Returns read data to the master in order.

Parameters:
- ADDR_WIDTH, 32, address width; bits [ADDR_WIDTH-1:ADDR_WIDTH-2] select the slave.
- DATA_WIDTH, 32, write/read data width.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_req  in  1  master request valid
- m_addr  in  ADDR_WIDTH  master address
- m_cmd  in  1  0 = read, 1 = write
- m_wdata  in  DATA_WIDTH  write data
- m_ack  out  1  request accepted this cycle
- m_resp  out  1  read data valid, one-cycle pulse
- m_rdata  out  DATA_WIDTH  read data
- xb_req  out  1  request to cross_bar
- xb_addr  out  ADDR_WIDTH  head entry address
- xb_cmd  out  1  head entry command
- xb_wdata  out  DATA_WIDTH  head entry write data
- xb_ack  in  1  cross_bar accepted head request
- xb_resp  in  1  cross_bar read response valid
- xb_rdata  in  DATA_WIDTH  cross_bar read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (asynchronous on rst_n low; all state, including mid-transaction state, is discarded):
  - Clears wr_ptr, rd_ptr, count and state (IDLE).
  - Drives xb_req=0, m_resp=0, m_rdata=0; xb_addr, xb_wdata and xb_cmd = 0.
  - Outputs empty=1, full=0.
- Push:
  - m_ack = m_req & ~full, combinational. There is deliberately no path from xb_ack, so a full queue never accepts a request even on a pop cycle.
  - On m_ack, {addr, cmd, wdata} is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Pop: head entry is retired at rd_ptr and rd_ptr wraps modulo DEPTH.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM states and transitions:
  - IDLE: xb_req=0. If count != 0, go to ISSUE next cycle. Latency from first push to xb_req = 1 cycle.
  - ISSUE: xb_req=1 and xb_* driven from the head entry, registered and stable until xb_ack.
    - xb_ack with cmd=1: pop; go to ISSUE if count after pop > 0, else IDLE. Back-to-back writes therefore issue with no bubble.
    - xb_ack with cmd=0: go to WAIT_RESP; xb_req drops the next cycle.
  - WAIT_RESP: xb_req=0. On xb_resp: pop, register m_rdata <= xb_rdata, pulse m_resp=1 in the next cycle, then go to ISSUE or IDLE by remaining count.
- xb_resp outside WAIT_RESP is ignored; xb_ack outside ISSUE is ignored.
- At most one request is outstanding, so responses are strictly in order.
- The head entry is held in place until popped; a new push never overwrites it.

Optional Feature:
- Macro: MASTER_REQ_FIFO_STATS_EN.
- Defined: adds output ports stat_accepted[15:0] (increments on each m_ack) and stat_stall[15:0] (increments each cycle m_req & full).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package master_req_pkg:
  - typedef struct packed {addr, cmd, wdata} req_entry_t
  - enum typedef fsm_state_t {IDLE, ISSUE, WAIT_RESP}
  - localparam CMD_READ = 1'b0, CMD_WRITE = 1'b1
  - ADDR_WIDTH/DATA_WIDTH are taken from interface_connection.
- Sub-module sync_fifo:
  - Storage, pointers and count, with push/pop/full/empty.
  - The FSM lives in master_req_fifo.

Test Plan:
- Single write, addr 32'h4000_0010, wdata 32'hDEAD_BEEF, xb_ack 2 cycles after xb_req -> m_ack same cycle; xb_req rises 1 cycle later with those values; count back to 0 and xb_req=0 the cycle after ack.
- Read addr 32'hC000_0004, xb_ack, then xb_resp with xb_rdata 32'h1234_5678 three cycles later -> m_resp one-cycle pulse with m_rdata 32'h1234_5678 one cycle after xb_resp; xb_req low throughout WAIT_RESP.
- Push 5 requests back-to-back with xb_ack held 0, DEPTH=4 -> first 4 get m_ack, full=1, count=4, 5th gets m_ack=0; after one xb_ack on a write, the 5th is accepted the following cycle.
- Alternating write/read/write queued, instant acks and resp -> issue order matches push order; only the read yields m_resp; count goes 3,2,1,0.
- Wrap-around: 10 sequential writes with incrementing wdata through DEPTH=4 -> xb_wdata sequence is exact and in order.
- Reset mid-operation: rst_n low during WAIT_RESP with count=3 -> immediately xb_req=0, count=0, empty=1; a late xb_resp after release causes no m_resp.
